vreg_wb_arbiter: RTL and testbench



---
 rtl/vreg_wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vreg_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_wb_arbiter.sv
// Round-robin write-port arbiter for the vector register file. Grants lock to one
// requester for multi-beat bursts and registers the winning beat toward the regfile.
module vreg_wb_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*2-1:0]      req_elems_i,
  input  logic [NUM_REQ-1:0]        req_widen_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic [1:0]                wr_elems_o,
  output logic                      wr_widen_o,
  output logic [1:0]                wr_src_o,
  output logic                      busy_o,
  output logic                      burst_err_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SumW = IdxW + 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic                err_d;

  logic                gnt_valid;
  logic [IdxW-1:0]     gnt_idx;
  logic [SumW-1:0]     rr_sum;
  logic                gnt_last;
  logic [DATA_W-1:0]   gnt_data;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [1:0]          gnt_elems;
  logic                gnt_widen;

  logic                wr_en_q, wr_widen_q, burst_err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [1:0]          wr_elems_q, wr_src_q;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Reset suppresses every handshake so a beat offered during reset is never lost silently.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_sum    = '0;
    if (!reset) begin
      if (state_q == StLocked) begin
        gnt_valid = req_valid_i[owner_q];
        gnt_idx   = owner_q;
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          rr_sum = {1'b0, rr_ptr_q} + SumW'(k);
          if (rr_sum >= SumW'(NUM_REQ)) rr_sum = rr_sum - SumW'(NUM_REQ);
          if (!gnt_valid && req_valid_i[rr_sum[IdxW-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_sum[IdxW-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_valid) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_last  = 1'b0;
    gnt_data  = '0;
    gnt_addr  = '0;
    gnt_elems = '0;
    gnt_widen = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) begin
        gnt_last  = req_last_i[i];
        gnt_data  = req_data_i[i*DATA_W +: DATA_W];
        gnt_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        gnt_elems = req_elems_i[i*2 +: 2];
        gnt_widen = req_widen_i[i];
      end
    end
  end

  assign beat_cnt_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          if (gnt_last) begin
            rr_ptr_d = next_idx(gnt_idx);
          end else begin
            state_d    = StLocked;
            owner_d    = gnt_idx;
            beat_cnt_d = CntW'(1);
          end
        end
      end
      StLocked: begin
        if (gnt_valid) begin
          beat_cnt_d = beat_cnt_inc;
          if (gnt_last || beat_cnt_inc == CntW'(MAX_BURST)) begin
            // An overrun beat is still written; only the lock is broken.
            state_d    = StIdle;
            rr_ptr_d   = next_idx(owner_q);
            beat_cnt_d = '0;
            err_d      = !gnt_last;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_elems_q  <= '0;
      wr_widen_q  <= 1'b0;
      wr_src_q    <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_en_q     <= gnt_valid;
      burst_err_q <= err_d;
      if (gnt_valid) begin
        wr_addr_q  <= gnt_addr;
        wr_data_q  <= gnt_data;
        wr_elems_q <= gnt_elems;
        wr_widen_q <= gnt_widen;
        wr_src_q   <= 2'(gnt_idx);
      end
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_elems_o  = wr_elems_q;
  assign wr_widen_o  = wr_widen_q;
  assign wr_src_o    = wr_src_q;
  assign busy_o      = (state_q == StLocked);
  assign burst_err_o = burst_err_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed scenarios plus random traffic on vreg_wb_arbiter, checked cycle by cycle
// against a transaction-level model of grants, locks and the registered write port.
module tb_vreg_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 128;
  localparam int AW = 5;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          tv_valid[NR];
  logic          tv_last[NR];
  logic          tv_widen[NR];
  logic [DW-1:0] tv_data[NR];
  logic [AW-1:0] tv_addr[NR];
  logic [1:0]    tv_elems[NR];

  logic [NR-1:0]    req_valid, req_last, req_widen, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR*AW-1:0] req_addr;
  logic [NR*2-1:0]  req_elems;
  logic             wr_en, wr_widen, busy, burst_err;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [1:0]       wr_elems, wr_src;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_widen = '0;
    req_data  = '0;
    req_addr  = '0;
    req_elems = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = tv_valid[i];
      req_last[i]           = tv_last[i];
      req_widen[i]          = tv_widen[i];
      req_data[i*DW +: DW]  = tv_data[i];
      req_addr[i*AW +: AW]  = tv_addr[i];
      req_elems[i*2 +: 2]   = tv_elems[i];
    end
  end

  vreg_wb_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_BURST(MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid),
    .req_last_i (req_last),
    .req_data_i (req_data),
    .req_addr_i (req_addr),
    .req_elems_i(req_elems),
    .req_widen_i(req_widen),
    .req_ready_o(req_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_elems_o (wr_elems),
    .wr_widen_o (wr_widen),
    .wr_src_o   (wr_src),
    .busy_o     (busy),
    .burst_err_o(burst_err)
  );

  int total = 0;
  int bad   = 0;

  // Model: lock owner (-1 when free), beats taken in the burst, next round-robin start.
  int            m_owner;
  int            m_cnt;
  int            m_rr;
  logic          e_en, e_widen, e_busy, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [1:0]    e_elems, e_src;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_rr    = 0;
    e_en    = 1'b0;
    e_widen = 1'b0;
    e_busy  = 1'b0;
    e_err   = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_elems = '0;
    e_src   = '0;
  endtask

  task automatic clr();
    for (int i = 0; i < NR; i++) begin
      tv_valid[i] = 1'b0;
      tv_last[i]  = 1'b0;
    end
  endtask

  task automatic put(input int i, input bit last, input int addr);
    tv_valid[i] = 1'b1;
    tv_last[i]  = last;
    tv_addr[i]  = AW'(addr);
    tv_data[i]  = {$urandom, $urandom, $urandom, $urandom};
    tv_elems[i] = 2'($urandom_range(0, 3));
    tv_widen[i] = 1'($urandom_range(0, 1));
  endtask

  // One clock: check mid-cycle, then advance the model over the coming edge.
  task automatic step();
    int            g;
    logic [NR-1:0] e_ready;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      if (m_owner >= 0) begin
        if (tv_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && tv_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        end
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    chk("ready", DW'(req_ready), DW'(e_ready));
    chk("wr_en", DW'(wr_en), DW'(e_en));
    chk("wr_addr", DW'(wr_addr), DW'(e_addr));
    chk("wr_data", wr_data, e_data);
    chk("wr_elems", DW'(wr_elems), DW'(e_elems));
    chk("wr_widen", DW'(wr_widen), DW'(e_widen));
    chk("busy", DW'(busy), DW'(e_busy));
    chk("burst_err", DW'(burst_err), DW'(e_err));
    if (e_en) chk("wr_src", DW'(wr_src), DW'(e_src));

    if (reset) begin
      model_reset();
    end else begin
      e_en  = (g >= 0);
      e_err = 1'b0;
      if (g >= 0) begin
        e_addr  = tv_addr[g];
        e_data  = tv_data[g];
        e_elems = tv_elems[g];
        e_widen = tv_widen[g];
        e_src   = 2'(g);
        if (m_owner < 0) begin
          if (tv_last[g]) m_rr = (g + 1) % NR;
          else begin
            m_owner = g;
            m_cnt   = 1;
          end
        end else begin
          m_cnt++;
          if (tv_last[g] || m_cnt == MB) begin
            e_err   = !tv_last[g];
            m_rr    = (m_owner + 1) % NR;
            m_owner = -1;
            m_cnt   = 0;
          end
        end
      end
      e_busy = (m_owner >= 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      tv_widen[i] = 1'b0;
      tv_data[i]  = '0;
      tv_addr[i]  = '0;
      tv_elems[i] = '0;
    end
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step();
    reset = 1'b0;

    // Single beat from req 0.
    put(0, 1'b1, 3);
    tv_data[0] = {4{32'hA5A5_A5A5}};
    step();
    clr();
    step();

    // All three requesters streaming single beats.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NR; i++) put(i, 1'b1, 4 * n + i);
      step();
    end
    clr();
    step();

    // Req 1 four-beat burst while reqs 0 and 2 wait.
    put(1, 1'b0, 8);
    step();
    for (int b = 1; b < 4; b++) begin
      put(0, 1'b1, 1);
      put(2, 1'b1, 2);
      put(1, b == 3, 8 + b);
      step();
    end
    tv_valid[1] = 1'b0;
    put(0, 1'b1, 1);
    put(2, 1'b1, 2);
    step();
    step();
    clr();
    step();

    // Owner gap mid-burst: lock holds while req 0 waits.
    put(1, 1'b0, 16);
    step();
    tv_valid[1] = 1'b0;
    put(0, 1'b1, 5);
    step();
    step();
    put(1, 1'b0, 17);
    step();
    put(1, 1'b1, 18);
    step();
    tv_valid[1] = 1'b0;
    step();
    clr();
    step();

    // Burst overrun from req 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      put(1, 1'b1, 7);
      put(0, 1'b0, 20 + b);
      step();
    end
    clr();
    put(1, 1'b1, 7);
    step();
    clr();
    step();

    // Reset on beat 2 of a burst, then a lone req 2 beat.
    reset = 1'b1;
    step();
    reset = 1'b0;
    put(0, 1'b0, 24);
    step();
    put(0, 1'b0, 25);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr();
    put(2, 1'b1, 30);
    step();
    clr();
    step();

    // Random traffic with occasional reset.
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) != 0) put(i, $urandom_range(0, 3) == 0, $urandom_range(0, 31));
        else tv_valid[i] = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    clr();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
